// File: rtl/alu_arb_if.sv
// Bundle of the alu_arb request, ALU and response channels.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface alu_arb_if #(
  parameter int WIDTH = 8
);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic [2:0]       r0_op;
  logic [2:0]       r0_shamt;
  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic [2:0]       r1_op;
  logic [2:0]       r1_shamt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [2:0]       alu_shamt;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic [3:0]       rsp_flags;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op, r0_shamt,
    input  r1_valid, r1_a, r1_b, r1_op, r1_shamt,
    output r0_ready, r1_ready,
    output alu_a, alu_b, alu_op, alu_shamt,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_id, rsp_out, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_op, r0_shamt,
    output r1_valid, r1_a, r1_b, r1_op, r1_shamt,
    input  r0_ready, r1_ready,
    input  alu_a, alu_b, alu_op, alu_shamt,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arb.sv
// Round-robin sharing of one fixed-latency ALU between two requesters,
// with the result returned on a valid/ready response channel tagged by id.
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// EXEC  | operands held on the ALU for ALU_LAT cycles
// RESP  | captured result presented until the consumer takes it
module alu_arb #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [2:0] LAST_CNT = 3'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [2:0]       alu_shamt_q, alu_shamt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             any_valid;
  logic             gnt;
  logic             r0_ready, r1_ready;

  assign any_valid = bus.r0_valid | bus.r1_valid;
  // Pointer only matters on a tie; a lone requester always wins.
  assign gnt = (bus.r0_valid & bus.r1_valid) ? ptr_q : bus.r1_valid;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_shamt_d = alu_shamt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
    r0_ready    = 1'b0;
    r1_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          r0_ready    = ~gnt;
          r1_ready    = gnt;
          alu_a_d     = gnt ? bus.r1_a     : bus.r0_a;
          alu_b_d     = gnt ? bus.r1_b     : bus.r0_b;
          alu_op_d    = gnt ? bus.r1_op    : bus.r0_op;
          alu_shamt_d = gnt ? bus.r1_shamt : bus.r0_shamt;
          id_d        = gnt;
          ptr_d       = ~gnt;
          cnt_d       = 3'd0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          rsp_out_d   = bus.alu_out;
          rsp_flags_d = bus.alu_flags;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= 3'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'd0;
      alu_shamt_q <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_flags_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_shamt_q <= alu_shamt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  // Reset leaves the FSM in IDLE, so ready must also be masked by rst_n.
  assign bus.r0_ready  = r0_ready & rst_n;
  assign bus.r1_ready  = r1_ready & rst_n;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_shamt = alu_shamt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: two instances (ALU_LAT 1 and 3), each with a behavioural ALU,
// per-requester expected-response queues and a negedge monitor.
module tb_alu_arb;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6;

  typedef logic [11:0] ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t exp_q[4][$];
  int   glog[$];
  bit   rdone;

  logic       rv  [2][2];
  logic [7:0] ra  [2][2];
  logic [7:0] rb  [2][2];
  logic [2:0] rop [2][2];
  logic [2:0] rsh [2][2];
  logic       rspr[2];

  logic       rdy0[2], rdy1[2], rvld[2], rid[2];
  logic [7:0] aa[2], ab[2], rout[2];
  logic [2:0] aop[2], ash[2];
  logic [3:0] rfl[2];

  logic       m_busy[2], m_seen[2], m_ptr[2], m_req[2];
  int         m_n[2];
  logic [7:0] m_a[2], m_b[2];
  logic [2:0] m_op[2], m_sh[2];
  ent_t       m_hold[2];

  // Reference ALU: returns {z,n,c,v,result}.
  function automatic ent_t alu_f(input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [2:0] sh);
    logic [8:0] s;
    logic [7:0] y;
    logic       c, v;
    s = 9'd0; y = 8'd0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b}; y = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      default: y = b;
    endcase
    return {(y == 8'h00), y[7], c, v, y};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;
    alu_arb_if #(.WIDTH(8)) bus ();
    alu_arb #(.WIDTH(8), .ALU_LAT(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.r0_valid = rv[g][0];
    assign bus.r0_a     = ra[g][0];
    assign bus.r0_b     = rb[g][0];
    assign bus.r0_op    = rop[g][0];
    assign bus.r0_shamt = rsh[g][0];
    assign bus.r1_valid = rv[g][1];
    assign bus.r1_a     = ra[g][1];
    assign bus.r1_b     = rb[g][1];
    assign bus.r1_op    = rop[g][1];
    assign bus.r1_shamt = rsh[g][1];
    assign bus.rsp_ready = rspr[g];
    assign rdy0[g] = bus.r0_ready;
    assign rdy1[g] = bus.r1_ready;
    assign rvld[g] = bus.rsp_valid;
    assign rid[g]  = bus.rsp_id;
    assign rout[g] = bus.rsp_out;
    assign rfl[g]  = bus.rsp_flags;
    assign aa[g]   = bus.alu_a;
    assign ab[g]   = bus.alu_b;
    assign aop[g]  = bus.alu_op;
    assign ash[g]  = bus.alu_shamt;

    if (L == 1) begin : g_comb
      assign {bus.alu_flags, bus.alu_out} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
    end else begin : g_pipe
      // Result only becomes valid L-1 edges after the operands settle.
      ent_t pipe [L-1];
      always @(posedge clk) begin
        pipe[0] <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
        for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign {bus.alu_flags, bus.alu_out} = pipe[L-2];
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  task automatic mon_step(input int g);
    int   lat;
    logic both, any, gnt;
    logic [1:0] er;
    ent_t e;
    lat = (g == 0) ? 1 : 3;
    if (!rst_n) begin
      m_busy[g] = 1'b0; m_seen[g] = 1'b0; m_ptr[g] = 1'b0;
      return;
    end
    if (m_busy[g]) begin
      m_n[g]++;
      chk("ready_busy", g, 32'({rdy0[g], rdy1[g]}), 0);
      chk("alu_hold", g, 32'({aa[g], ab[g], aop[g], ash[g]}), 32'({m_a[g], m_b[g], m_op[g], m_sh[g]}));
      if (!m_seen[g]) begin
        chk("rsp_timing", g, 32'(rvld[g]), 32'(m_n[g] > lat));
        if (rvld[g]) begin
          m_seen[g] = 1'b1;
          m_hold[g] = {rfl[g], rout[g]};
          chk("rsp_id", g, 32'(rid[g]), 32'(m_req[g]));
          if (exp_q[g*2 + int'(m_req[g])].size() == 0) chk("rsp_unexpected", g, 1, 0);
          else begin
            e = exp_q[g*2 + int'(m_req[g])].pop_front();
            chk("rsp_data", g, 32'({rfl[g], rout[g]}), 32'(e));
          end
        end
      end else begin
        chk("rsp_stable", g, 32'({rvld[g], rid[g], rfl[g], rout[g]}), 32'({1'b1, m_req[g], m_hold[g]}));
      end
      if (m_seen[g] && rvld[g] && rspr[g]) begin
        m_busy[g] = 1'b0; m_seen[g] = 1'b0;
      end
    end else begin
      chk("rsp_idle", g, 32'(rvld[g]), 0);
      both = rv[g][0] & rv[g][1];
      any  = rv[g][0] | rv[g][1];
      gnt  = both ? m_ptr[g] : rv[g][1];
      er   = !any ? 2'b00 : (gnt ? 2'b01 : 2'b10);
      chk("ready_grant", g, 32'({rdy0[g], rdy1[g]}), 32'(er));
      if (any) begin
        m_busy[g] = 1'b1; m_n[g] = 0; m_req[g] = gnt;
        m_a[g]  = ra[g][int'(gnt)];  m_b[g]  = rb[g][int'(gnt)];
        m_op[g] = rop[g][int'(gnt)]; m_sh[g] = rsh[g][int'(gnt)];
        m_ptr[g] = ~gnt;
        if (g == 0) glog.push_back(int'(gnt));
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    for (int g = 0; g < 2; g++) mon_step(g);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int g, input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [2:0] sh, input ent_t e);
    bit ok;
    ok = 1'b0;
    exp_q[g*2 + r].push_back(e);
    rv[g][r] = 1'b1; ra[g][r] = a; rb[g][r] = b; rop[g][r] = op; rsh[g][r] = sh;
    for (int i = 0; i < 60 && !ok; i++) begin
      #1;
      if ((r == 0) ? rdy0[g] : rdy1[g]) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    rv[g][r] = 1'b0;
    chk("issue_accept", g, 32'(ok), 1);
  endtask

  task automatic rand_issue(input int g, input int r);
    logic [7:0] a, b;
    logic [2:0] op, sh;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom_range(0, 7));
    sh = 3'($urandom_range(0, 7));
    issue(g, r, a, b, op, sh, alu_f(op, a, b, sh));
  endtask

  task automatic req_loop(input int g, input int r, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rand_issue(g, r);
    end
  endtask

  task automatic drain(input int g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      #3;
      if (exp_q[g*2].size() == 0 && exp_q[g*2+1].size() == 0 && !m_busy[g] && !rvld[g]) ok = 1'b1;
    end
    @(negedge clk);
    chk("drain", g, 32'(ok), 1);
  endtask

  task automatic chk_reset(input int g);
    chk("rst_ready", g, 32'({rdy0[g], rdy1[g]}), 0);
    chk("rst_alu", g, 32'({aa[g], ab[g], aop[g], ash[g]}), 0);
    chk("rst_rsp", g, 32'({rvld[g], rid[g], rfl[g], rout[g]}), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int q = 0; q < 4; q++) exp_q[q].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rspr[g] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        rv[g][r] = 1'b0; ra[g][r] = 8'd0; rb[g][r] = 8'd0; rop[g][r] = 3'd0; rsh[g][r] = 3'd0;
      end
    end
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    rv[0][0] = 1'b1; rv[0][1] = 1'b1;
    #1;
    chk_reset(0);
    chk_reset(1);
    repeat (2) @(negedge clk);
    rv[0][0] = 1'b0; rv[0][1] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 0, 8'h12, 8'h34, OP_ADD, 3'd0, {4'b0000, 8'h46});
    drain(0);
    issue(0, 1, 8'hFF, 8'h01, OP_ADD, 3'd0, {4'b1010, 8'h00});
    drain(0);
    issue(0, 0, 8'h7F, 8'h01, OP_ADD, 3'd0, {4'b0101, 8'h80});
    drain(0);

    // Both requesters valid straight out of reset: strict alternation from r0.
    @(negedge clk);
    do_reset();
    glog.delete();
    fork
      begin rand_issue(0, 0); rand_issue(0, 0); end
      begin rand_issue(0, 1); rand_issue(0, 1); end
    join
    drain(0);
    chk("grant_count", 0, 32'(glog.size()), 4);
    for (int i = 0; i < glog.size() && i < 4; i++) chk("grant_order", 0, 32'(glog[i]), 32'(i % 2));

    // Response held off by the consumer while r0 waits.
    rspr[0] = 1'b0;
    issue(0, 1, 8'h05, 8'h07, OP_SUB, 3'd0, {4'b0110, 8'hFE});
    fork
      issue(0, 0, 8'h21, 8'h03, OP_XOR, 3'd0, {4'b0000, 8'h22});
      begin
        repeat (6) @(negedge clk);
        chk("hold_valid", 0, 32'(rvld[0]), 1);
        rspr[0] = 1'b1;
      end
    join
    drain(0);

    issue(1, 0, 8'h12, 8'h34, OP_ADD, 3'd0, {4'b0000, 8'h46});
    drain(1);
    issue(1, 1, 8'hFF, 8'h01, OP_ADD, 3'd0, {4'b1010, 8'h00});
    drain(1);
    issue(1, 0, 8'h81, 8'h00, OP_SHR, 3'd3, {4'b0000, 8'h10});
    drain(1);

    for (int g = 0; g < 2; g++) begin
      rdone = 1'b0;
      fork
        begin
          fork
            req_loop(g, 0, (g == 0) ? 25 : 15);
            req_loop(g, 1, (g == 0) ? 25 : 15);
          join
          rdone = 1'b1;
        end
        begin
          while (!rdone) begin
            @(negedge clk);
            rspr[g] = ($urandom_range(0, 3) != 0);
          end
        end
      join
      rspr[g] = 1'b1;
      drain(g);
    end

    // Reset while r0's operation is in EXEC; pointer must come back to r0.
    issue(0, 0, 8'hA5, 8'h5A, OP_OR, 3'd0, {4'b0100, 8'hFF});
    rv[0][1] = 1'b1; ra[0][1] = 8'h33;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    for (int q = 0; q < 4; q++) exp_q[q].delete();
    rv[0][1] = 1'b0;
    repeat (2) @(negedge clk);
    glog.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    fork
      issue(0, 0, 8'h01, 8'h02, OP_ADD, 3'd0, {4'b0000, 8'h03});
      issue(0, 1, 8'h0F, 8'h3C, OP_AND, 3'd0, {4'b0000, 8'h0C});
    join
    drain(0);
    chk("post_rst_grant_count", 0, 32'(glog.size()), 2);
    if (glog.size() > 0) chk("post_rst_first_grant", 0, 32'(glog[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
